// File: rtl/issue_queue_pkg.sv
// Shared widths and the stored-entry layout for the issue queue family.
// Sub-blocks and later queues import this package so all of them use the same entry format.
package issue_queue_pkg;

  localparam int DISPATCH_WIDTH       = 2;
  localparam int PHYS_REGS_ADDR_WIDTH = 6;
  localparam int IQ_DEPTH             = 8;
  localparam int WB_WIDTH             = 2;
  localparam int PAYLOAD_WIDTH        = 16;
  localparam int XLEN                 = 32;

  typedef struct packed {
    logic                     valid;
    logic [XLEN-1:0]          op1;
    logic                     op1_valid;
    logic [XLEN-1:0]          op2;
    logic                     op2_valid;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } iq_entry_t;

endpackage

// File: rtl/issue_queue_select.sv
// Oldest-ready picker: the lowest-index set bit of ready wins.
// Produces both a one-hot grant and a binary index so callers can mux or shift with either.
module issue_select
  import issue_queue_pkg::*;
#(
  parameter int N = IQ_DEPTH
) (
  input  logic [N-1:0]                        ready,
  output logic                                any_ready,
  output logic [N-1:0]                        onehot,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] idx
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // priority encode, scanning from the youngest so the oldest hit is written last
  always_comb begin
    any_ready = |ready;
    onehot    = '0;
    idx       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ready[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end else begin
        onehot = onehot;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Collapsing age-ordered issue queue: slot 0 is the oldest entry, occupied slots are contiguous,
// pending operands are woken by writeback broadcasts and the oldest fully-ready entry issues.
module issue_queue
  import issue_queue_pkg::iq_entry_t;
#(
  parameter int DISPATCH_WIDTH       = issue_queue_pkg::DISPATCH_WIDTH,
  parameter int PHYS_REGS_ADDR_WIDTH = issue_queue_pkg::PHYS_REGS_ADDR_WIDTH,
  parameter int IQ_DEPTH             = issue_queue_pkg::IQ_DEPTH,
  parameter int WB_WIDTH             = issue_queue_pkg::WB_WIDTH,
  parameter int PAYLOAD_WIDTH        = issue_queue_pkg::PAYLOAD_WIDTH
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           flush,
  input  logic [DISPATCH_WIDTH-1:0]                      dispatch_valid,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                dispatch_op1,
  input  logic [DISPATCH_WIDTH-1:0][31:0]                dispatch_op2,
  input  logic [DISPATCH_WIDTH-1:0]                      dispatch_op1_valid,
  input  logic [DISPATCH_WIDTH-1:0]                      dispatch_op2_valid,
  input  logic [DISPATCH_WIDTH-1:0][PAYLOAD_WIDTH-1:0]   dispatch_payload,
  output logic                                           dispatch_ready,
  input  logic [WB_WIDTH-1:0]                            wb_valid,
  input  logic [WB_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  wb_tag,
  input  logic [WB_WIDTH-1:0][31:0]                      wb_data,
  output logic                                           issue_valid,
  input  logic                                           issue_ready,
  output logic [31:0]                                    issue_op1,
  output logic [31:0]                                    issue_op2,
  output logic [PAYLOAD_WIDTH-1:0]                       issue_payload,
  output logic [$clog2(IQ_DEPTH+1)-1:0]                  count
);

  localparam int CW    = $clog2(IQ_DEPTH + 1);
  localparam int IDX_W = $clog2(IQ_DEPTH);
  localparam int NCAND = IQ_DEPTH + DISPATCH_WIDTH;

  iq_entry_t                   slots_r [IQ_DEPTH];
  iq_entry_t                   next_s  [IQ_DEPTH];
  iq_entry_t [NCAND-1:0]       cand_s;
  iq_entry_t [NCAND-1:0]       woke_s;
  logic [CW-1:0]               count_r;
  logic [CW-1:0]               base_s;
  logic [CW-1:0]               next_count_s;
  logic [IQ_DEPTH-1:0]         ready_s;
  logic [IQ_DEPTH-1:0]         sel_onehot_s;
  logic [IDX_W-1:0]            sel_idx_s;
  logic                        any_ready_s;
  logic                        fire_s;
  logic                        dispatch_ready_s;
  logic [DISPATCH_WIDTH-1:0]   accept_s;
  logic [31:0]                 sel_op1_s;
  logic [31:0]                 sel_op2_s;
  logic [PAYLOAD_WIDTH-1:0]    sel_payload_s;

  // Returns {valid, value}; ports are scanned high to low so the lowest matching port wins.
  function automatic logic [32:0] wake_op(
    input logic                                          op_valid,
    input logic [31:0]                                   op,
    input logic [WB_WIDTH-1:0]                           v,
    input logic [WB_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] tag,
    input logic [WB_WIDTH-1:0][31:0]                     data
  );
    logic [32:0] res;
    res = {op_valid, op};
    for (int k = WB_WIDTH - 1; k >= 0; k--) begin
      if (!op_valid && v[k] && (tag[k] == op[PHYS_REGS_ADDR_WIDTH-1:0])) begin
        res = {1'b1, data[k]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // wakeup candidates: every stored slot followed by every incoming dispatch lane
  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      cand_s[i] = slots_r[i];
    end
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      cand_s[IQ_DEPTH+j] = iq_entry_t'{
        valid:     dispatch_valid[j],
        op1:       dispatch_op1[j],
        op1_valid: dispatch_op1_valid[j],
        op2:       dispatch_op2[j],
        op2_valid: dispatch_op2_valid[j],
        payload:   dispatch_payload[j]
      };
    end
  end

  for (genvar c = 0; c < NCAND; c++) begin : g_wake
    logic [32:0] w1_s;
    logic [32:0] w2_s;
    assign w1_s = wake_op(cand_s[c].op1_valid, cand_s[c].op1, wb_valid, wb_tag, wb_data);
    assign w2_s = wake_op(cand_s[c].op2_valid, cand_s[c].op2, wb_valid, wb_tag, wb_data);
    assign woke_s[c] = iq_entry_t'{
      valid:     cand_s[c].valid,
      op1:       w1_s[31:0],
      op1_valid: w1_s[32],
      op2:       w2_s[31:0],
      op2_valid: w2_s[32],
      payload:   cand_s[c].payload
    };
  end

  // readiness uses only registered flags, so a wakeup becomes issuable one cycle later
  always_comb begin
    for (int i = 0; i < IQ_DEPTH; i++) begin
      ready_s[i] = slots_r[i].valid & slots_r[i].op1_valid & slots_r[i].op2_valid;
    end
  end

  issue_select #(
    .N (IQ_DEPTH)
  ) u_select (
    .ready     (ready_s),
    .any_ready (any_ready_s),
    .onehot    (sel_onehot_s),
    .idx       (sel_idx_s)
  );

  // operand/payload mux for the granted slot
  always_comb begin
    sel_op1_s     = 32'd0;
    sel_op2_s     = 32'd0;
    sel_payload_s = {PAYLOAD_WIDTH{1'b0}};
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (sel_onehot_s[i]) begin
        sel_op1_s     = slots_r[i].op1;
        sel_op2_s     = slots_r[i].op2;
        sel_payload_s = slots_r[i].payload;
      end else begin
        sel_op1_s = sel_op1_s;
      end
    end
  end

  assign issue_valid      = any_ready_s & ~flush;
  assign fire_s           = issue_valid & issue_ready;
  assign dispatch_ready_s = (count_r <= CW'(IQ_DEPTH - DISPATCH_WIDTH)) & ~flush;
  assign dispatch_ready   = dispatch_ready_s;
  assign issue_op1        = issue_valid ? sel_op1_s : 32'd0;
  assign issue_op2        = issue_valid ? sel_op2_s : 32'd0;
  assign issue_payload    = issue_valid ? sel_payload_s : {PAYLOAD_WIDTH{1'b0}};
  assign count            = count_r;

  // collapse above the issued slot, then append accepted lanes at the new tail
  always_comb begin
    base_s       = count_r - {{(CW-1){1'b0}}, fire_s};
    next_count_s = base_s;
    for (int j = 0; j < DISPATCH_WIDTH; j++) begin
      accept_s[j]  = dispatch_ready_s & dispatch_valid[j];
      next_count_s = next_count_s + {{(CW-1){1'b0}}, accept_s[j]};
    end
    for (int i = 0; i < IQ_DEPTH; i++) begin
      if (fire_s && (i >= int'(sel_idx_s))) begin
        if (i == IQ_DEPTH - 1) begin
          next_s[i] = '0;
        end else begin
          next_s[i] = woke_s[i+1];
        end
      end else begin
        next_s[i] = woke_s[i];
      end
      for (int j = 0; j < DISPATCH_WIDTH; j++) begin
        if (accept_s[j] && ((int'(base_s) + j) == i)) begin
          next_s[i] = woke_s[IQ_DEPTH+j];
        end else begin
          next_s[i] = next_s[i];
        end
      end
    end
  end

  // slot and occupancy state; flush drops everything including same-cycle dispatch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        slots_r[i] <= '0;
      end
      count_r <= '0;
    end else if (flush) begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        slots_r[i] <= '0;
      end
      count_r <= '0;
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++) begin
        slots_r[i] <= next_s[i];
      end
      count_r <= next_count_s;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: a queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_issue_queue;

  localparam int DW    = 2;
  localparam int WB    = 2;
  localparam int DEPTH = 8;
  localparam int PW    = 16;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic [DW-1:0]         dispatch_valid;
  logic [DW-1:0][31:0]   dispatch_op1;
  logic [DW-1:0][31:0]   dispatch_op2;
  logic [DW-1:0]         dispatch_op1_valid;
  logic [DW-1:0]         dispatch_op2_valid;
  logic [DW-1:0][PW-1:0] dispatch_payload;
  logic                  dispatch_ready;
  logic [WB-1:0]         wb_valid;
  logic [WB-1:0][5:0]    wb_tag;
  logic [WB-1:0][31:0]   wb_data;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [31:0]           issue_op1;
  logic [31:0]           issue_op2;
  logic [PW-1:0]         issue_payload;
  logic [3:0]            count;

  issue_queue dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .dispatch_valid     (dispatch_valid),
    .dispatch_op1       (dispatch_op1),
    .dispatch_op2       (dispatch_op2),
    .dispatch_op1_valid (dispatch_op1_valid),
    .dispatch_op2_valid (dispatch_op2_valid),
    .dispatch_payload   (dispatch_payload),
    .dispatch_ready     (dispatch_ready),
    .wb_valid           (wb_valid),
    .wb_tag             (wb_tag),
    .wb_data            (wb_data),
    .issue_valid        (issue_valid),
    .issue_ready        (issue_ready),
    .issue_op1          (issue_op1),
    .issue_op2          (issue_op2),
    .issue_payload      (issue_payload),
    .count              (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op1;
    logic        v1;
    logic [31:0] op2;
    logic        v2;
    logic [15:0] pl;
  } ment_t;

  ment_t mq[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    exp_iv;
  bit    exp_dr;
  int    exp_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ment_t wake_e(input ment_t e);
    ment_t r;
    r = e;
    for (int k = 0; k < WB; k++) begin
      if (!r.v1 && wb_valid[k] && wb_tag[k] == e.op1[5:0]) begin r.op1 = wb_data[k]; r.v1 = 1'b1; end
      if (!r.v2 && wb_valid[k] && wb_tag[k] == e.op2[5:0]) begin r.op2 = wb_data[k]; r.v2 = 1'b1; end
    end
    return r;
  endfunction

  // Compare DUT outputs with the model for the current (pre-edge) cycle.
  task automatic cmp();
    bit any;
    #1;
    any = 1'b0;
    exp_sel = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (!any && mq[i].v1 && mq[i].v2) begin any = 1'b1; exp_sel = i; end
    end
    exp_iv = any && !flush;
    exp_dr = (mq.size() <= DEPTH - DW) && !flush;
    chk("m_issue_valid", 32'(issue_valid), 32'(exp_iv));
    chk("m_dispatch_ready", 32'(dispatch_ready), 32'(exp_dr));
    chk("m_count", 32'(count), 32'(mq.size()));
    if (exp_iv) begin
      chk("m_issue_op1", issue_op1, mq[exp_sel].op1);
      chk("m_issue_op2", issue_op2, mq[exp_sel].op2);
      chk("m_issue_payload", 32'(issue_payload), 32'(mq[exp_sel].pl));
    end
  endtask

  // Advance the model across the coming clock edge, then move to the next negedge.
  task automatic adv();
    ment_t nq[$];
    ment_t ln;
    if (flush) begin
      mq.delete();
    end else begin
      for (int i = 0; i < mq.size(); i++) begin
        if (!(exp_iv && issue_ready && i == exp_sel)) nq.push_back(wake_e(mq[i]));
      end
      if (exp_dr) begin
        for (int j = 0; j < DW; j++) begin
          if (dispatch_valid[j]) begin
            ln.op1 = dispatch_op1[j]; ln.v1 = dispatch_op1_valid[j];
            ln.op2 = dispatch_op2[j]; ln.v2 = dispatch_op2_valid[j];
            ln.pl  = dispatch_payload[j];
            nq.push_back(wake_e(ln));
          end
        end
      end
      mq = nq;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    cmp();
    adv();
  endtask

  task automatic clr();
    dispatch_valid = '0; dispatch_op1 = '0; dispatch_op2 = '0;
    dispatch_op1_valid = '0; dispatch_op2_valid = '0; dispatch_payload = '0;
  endtask

  task automatic clr_wb();
    wb_valid = '0; wb_tag = '0; wb_data = '0;
  endtask

  task automatic lane(input int j, input logic [31:0] o1, input logic v1,
                      input logic [31:0] o2, input logic v2, input logic [15:0] pl);
    dispatch_valid[j] = 1'b1; dispatch_op1[j] = o1; dispatch_op1_valid[j] = v1;
    dispatch_op2[j] = o2; dispatch_op2_valid[j] = v2; dispatch_payload[j] = pl;
  endtask

  task automatic wb(input int k, input logic [5:0] t, input logic [31:0] d);
    wb_valid[k] = 1'b1; wb_tag[k] = t; wb_data[k] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; issue_ready = 1'b0;
    clr(); clr_wb();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    cmp();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    chk("rst_issue_op1", issue_op1, 32'd0);
    chk("rst_issue_op2", issue_op2, 32'd0);
    chk("rst_issue_payload", 32'(issue_payload), 32'd0);
    adv();

    // two ready ops issue in order on consecutive cycles
    issue_ready = 1'b1;
    lane(0, 32'd5, 1'b1, 32'd7, 1'b1, 16'h0011);
    lane(1, 32'd1, 1'b1, 32'd2, 1'b1, 16'h0022);
    tick();
    clr();
    cmp();
    chk("t1_valid0", 32'(issue_valid), 32'd1);
    chk("t1_op1_0", issue_op1, 32'd5);
    chk("t1_op2_0", issue_op2, 32'd7);
    chk("t1_pl_0", 32'(issue_payload), 32'h0011);
    adv();
    cmp();
    chk("t1_op1_1", issue_op1, 32'd1);
    chk("t1_op2_1", issue_op2, 32'd2);
    adv();
    cmp();
    chk("t1_count_end", 32'(count), 32'd0);
    adv();

    // pending op2 tag 12, woken two cycles later; op1 value 12 is data and stays untouched
    lane(0, 32'd12, 1'b1, 32'd12, 1'b0, 16'h0033);
    tick();
    clr();
    tick();
    wb(0, 6'd12, 32'hDEAD);
    wb(1, 6'd13, 32'hBAD);
    cmp();
    chk("t2_not_yet", 32'(issue_valid), 32'd0);
    adv();
    clr_wb();
    cmp();
    chk("t2_valid", 32'(issue_valid), 32'd1);
    chk("t2_op1", issue_op1, 32'd12);
    chk("t2_op2", issue_op2, 32'hDEAD);
    adv();
    cmp();
    chk("t2_count_end", 32'(count), 32'd0);
    adv();

    // fill with blocked entries (slot i waits on tag 20+i)
    for (int p = 0; p < 4; p++) begin
      lane(0, 32'(20 + 2 * p), 1'b0, 32'd1, 1'b1, 16'(2 * p));
      lane(1, 32'(21 + 2 * p), 1'b0, 32'd2, 1'b1, 16'(2 * p + 1));
      tick();
    end
    clr();
    lane(0, 32'd99, 1'b1, 32'd99, 1'b1, 16'h00EE);
    cmp();
    chk("t3_full_count", 32'(count), 32'd8);
    chk("t3_full_ready", 32'(dispatch_ready), 32'd0);
    adv();
    clr();
    wb(0, 6'd23, 32'h1234);
    cmp();
    chk("t3_full_still", 32'(count), 32'd8);
    adv();
    clr_wb();
    cmp();
    chk("t3_slot3_pl", 32'(issue_payload), 32'd3);
    chk("t3_slot3_op1", issue_op1, 32'h1234);
    adv();
    lane(0, 32'd98, 1'b1, 32'd98, 1'b1, 16'h00EF);
    cmp();
    chk("t3_count7", 32'(count), 32'd7);
    chk("t3_ready_at7", 32'(dispatch_ready), 32'd0);
    adv();
    clr();
    wb(0, 6'd24, 32'h44);
    tick();
    clr_wb();
    cmp();
    chk("t3_shift_pl", 32'(issue_payload), 32'd4);
    chk("t3_shift_op1", issue_op1, 32'h44);
    adv();
    cmp();
    chk("t3_count6", 32'(count), 32'd6);
    chk("t3_ready_at6", 32'(dispatch_ready), 32'd1);
    adv();
    wb(0, 6'd25, 32'h55);
    wb(1, 6'd22, 32'h22);
    tick();
    clr_wb();
    cmp();
    chk("t3_oldest_first", 32'(issue_payload), 32'd2);
    adv();
    cmp();
    chk("t3_then_younger", 32'(issue_payload), 32'd5);
    adv();
    flush = 1'b1;
    cmp();
    chk("t3_flush_iv", 32'(issue_valid), 32'd0);
    adv();
    flush = 1'b0;
    cmp();
    chk("t3_flush_count", 32'(count), 32'd0);
    adv();

    // same-cycle dispatch + wakeup, two ports on one tag: port 0 wins
    lane(0, 32'd9, 1'b0, 32'h77, 1'b1, 16'h0044);
    wb(0, 6'd9, 32'h55);
    wb(1, 6'd9, 32'h66);
    cmp();
    chk("t4_not_yet", 32'(issue_valid), 32'd0);
    adv();
    clr(); clr_wb();
    cmp();
    chk("t4_valid", 32'(issue_valid), 32'd1);
    chk("t4_op1", issue_op1, 32'h55);
    chk("t4_op2", issue_op2, 32'h77);
    adv();
    lane(0, 32'd10, 1'b0, 32'h88, 1'b1, 16'h0045);
    tick();
    clr();
    wb(0, 6'd10, 32'hA0);
    wb(1, 6'd10, 32'hB0);
    tick();
    clr_wb();
    cmp();
    chk("t4_stored_port0", issue_op1, 32'hA0);
    adv();
    tick();

    // back-pressure holds the issue outputs
    issue_ready = 1'b0;
    lane(0, 32'h100, 1'b1, 32'h200, 1'b1, 16'h0055);
    tick();
    clr();
    for (int c = 0; c < 3; c++) begin
      cmp();
      chk("t5_hold_valid", 32'(issue_valid), 32'd1);
      chk("t5_hold_op1", issue_op1, 32'h100);
      chk("t5_hold_op2", issue_op2, 32'h200);
      chk("t5_hold_count", 32'(count), 32'd1);
      adv();
    end
    issue_ready = 1'b1;
    tick();

    // flush while dispatching with an entry present
    issue_ready = 1'b0;
    lane(0, 32'd3, 1'b1, 32'd4, 1'b1, 16'h0066);
    tick();
    issue_ready = 1'b1;
    lane(0, 32'd5, 1'b1, 32'd6, 1'b1, 16'h0067);
    lane(1, 32'd7, 1'b1, 32'd8, 1'b1, 16'h0068);
    flush = 1'b1;
    cmp();
    chk("t6_flush_iv", 32'(issue_valid), 32'd0);
    chk("t6_flush_dr", 32'(dispatch_ready), 32'd0);
    adv();
    flush = 1'b0;
    clr();
    cmp();
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_nothing", 32'(issue_valid), 32'd0);
    adv();

    // asynchronous reset mid-operation
    issue_ready = 1'b0;
    lane(0, 32'd1, 1'b1, 32'd1, 1'b1, 16'h0070);
    lane(1, 32'd2, 1'b1, 32'd2, 1'b1, 16'h0071);
    tick();
    clr();
    rst = 1'b1;
    #2;
    chk("t7_async_count", 32'(count), 32'd0);
    chk("t7_async_iv", 32'(issue_valid), 32'd0);
    mq.delete();
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
